// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JREG   = 2'd3
  } next_pc_sel_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch control/status bundle between the datapath (master) and fetch_pc_unit (slave).
// Optional FETCH_PERF_CNT_EN adds the fetch/redirect counter outputs.
interface fetch_pc_unit_if;
  logic        stall;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misaligned;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  // There is no valid/ready pair: every control input is sampled on each
  // rising edge in RUN unless stall is high, and pc/status are always valid.
  modport master (
    output stall, instruction, branch_taken, branch_offset,
           jump, jump_index, jump_reg, jr_target,
    input  pc, pc_plus4, halted, misaligned
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count, redirect_count
`endif
  );

  modport slave (
    input  stall, instruction, branch_taken, branch_offset,
           jump, jump_index, jump_reg, jr_target,
    output pc, pc_plus4, halted, misaligned
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count, redirect_count
`endif
  );
endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC select: jump_reg > jump > branch_taken > sequential.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [31:0]  pc_i,
  input  logic         branch_taken_i,
  input  logic [31:0]  branch_offset_i,
  input  logic         jump_i,
  input  logic [25:0]  jump_index_i,
  input  logic         jump_reg_i,
  input  logic [31:0]  jr_target_i,
  output logic [31:0]  pc_plus4_o,
  output logic [31:0]  next_pc_o,
  output next_pc_sel_t sel_o,
  output logic         jr_misaligned_o
);

  always_comb begin
    pc_plus4_o      = pc_i + WORD_BYTES;
    jr_misaligned_o = (jr_target_i[1:0] != 2'b00);
    sel_o           = SEQ;
    if (jump_reg_i)          sel_o = JREG;
    else if (jump_i)         sel_o = JUMP;
    else if (branch_taken_i) sel_o = BRANCH;

    // Branch offset is in words; the shift drops bits [31:30] on purpose.
    case (sel_o)
      JREG:    next_pc_o = {jr_target_i[31:2], 2'b00};
      JUMP:    next_pc_o = {pc_plus4_o[31:28], jump_index_i, 2'b00};
      BRANCH:  next_pc_o = pc_plus4_o + (branch_offset_i << 2);
      default: next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, BOOT/RUN/HALT sequencer and NOP-run halt detector.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / redirect_count.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          HALT_NOP_COUNT = 4,
  parameter int          NOP_CNT_W      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_pc_unit_if.slave bus,
  output fetch_state_t state_dbg_o
);

  fetch_state_t         state_q;
  logic [31:0]          pc_q;
  logic [NOP_CNT_W-1:0] nop_cnt_q;
  logic                 halted_q;
  logic                 misaligned_q;

  logic [31:0]          pc_plus4;
  logic [31:0]          next_pc;
  next_pc_sel_t         sel;
  logic                 jr_misaligned;
  logic                 fetch_go;
  logic                 is_nop;
  logic [NOP_CNT_W:0]   nop_cnt_d;
  logic                 halt_hit;

  next_pc_mux u_next_pc_mux (
    .pc_i            (pc_q),
    .branch_taken_i  (bus.branch_taken),
    .branch_offset_i (bus.branch_offset),
    .jump_i          (bus.jump),
    .jump_index_i    (bus.jump_index),
    .jump_reg_i      (bus.jump_reg),
    .jr_target_i     (bus.jr_target),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (next_pc),
    .sel_o           (sel),
    .jr_misaligned_o (jr_misaligned)
  );

  always_comb begin
    fetch_go  = (state_q == RUN) && !bus.stall;
    is_nop    = (bus.instruction == NOP_INSTR);
    nop_cnt_d = {1'b0, nop_cnt_q} + 1'b1;
    // The counter is one wider than stored so the compare sees the value it would reach.
    halt_hit  = (HALT_NOP_COUNT > 0) && is_nop && (int'(nop_cnt_d) == HALT_NOP_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      nop_cnt_q    <= '0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (fetch_go) begin
            pc_q <= next_pc;
            if ((sel == JREG) && jr_misaligned) misaligned_q <= 1'b1;
            if (HALT_NOP_COUNT > 0) begin
              if (is_nop) nop_cnt_q <= nop_cnt_d[NOP_CNT_W-1:0];
              else        nop_cnt_q <= '0;
              if (halt_hit) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end
            end
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else if (fetch_go) begin
      if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((sel != SEQ) && (redirect_cnt_q != 32'hFFFF_FFFF))
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.redirect_count = redirect_cnt_q;
`endif

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.halted     = halted_q;
  assign bus.misaligned = misaligned_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized and directed bench for fetch_pc_unit against a behavioural PC model.
module tb_fetch_pc_unit;
  import mips_pkg::*;

  logic         clk;
  logic         rst_n;
  fetch_state_t state_dbg;
  int           checks;
  int           errors;

  fetch_pc_unit_if bus_if ();

  fetch_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout pc=%h", bus_if.pc);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_booted;
  bit          m_halt;
  bit          m_mis;
  int          m_run;
  longint      m_fetch;
  longint      m_redir;

  task automatic model_reset();
    m_pc = 32'h0; m_booted = 0; m_halt = 0; m_mis = 0; m_run = 0;
    m_fetch = 0; m_redir = 0;
  endtask

  // One rising edge worth of behaviour, from the inputs currently applied.
  task automatic model_edge();
    logic [31:0] seq;
    if (m_halt) return;
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    if (bus_if.stall) return;
    seq = m_pc + 32'd4;
    m_fetch++;
    if (bus_if.jump_reg || bus_if.jump || bus_if.branch_taken) m_redir++;
    if (bus_if.jump_reg) begin
      m_pc = bus_if.jr_target & 32'hFFFF_FFFC;
      if (bus_if.jr_target % 4 != 0) m_mis = 1;
    end else if (bus_if.jump) begin
      m_pc = (seq & 32'hF000_0000) | (32'(bus_if.jump_index) * 4);
    end else if (bus_if.branch_taken) begin
      m_pc = seq + bus_if.branch_offset * 4;
    end else begin
      m_pc = seq;
    end
    if (bus_if.instruction == 32'h0) m_run++;
    else m_run = 0;
    if (m_run == 4) m_halt = 1;
  endtask

  // ---------------- checking ----------------
  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    fetch_state_t exp_state;
    exp_state = m_halt ? HALT : (m_booted ? RUN : BOOT);
    check_val("pc", bus_if.pc, m_pc);
    check_val("pc_plus4", bus_if.pc_plus4, m_pc + 32'd4);
    check_val("halted", 32'(bus_if.halted), 32'(m_halt));
    check_val("misaligned", 32'(bus_if.misaligned), 32'(m_mis));
    check_val("state", 32'(state_dbg), 32'(exp_state));
`ifdef FETCH_PERF_CNT_EN
    check_val("fetch_count", bus_if.fetch_count, 32'(m_fetch));
    check_val("redirect_count", bus_if.redirect_count, 32'(m_redir));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit st, logic [31:0] ins, bit br, logic [31:0] off,
                       bit j, logic [25:0] idx, bit jr, logic [31:0] tgt);
    bus_if.stall = st;       bus_if.instruction = ins;
    bus_if.branch_taken = br; bus_if.branch_offset = off;
    bus_if.jump = j;         bus_if.jump_index = idx;
    bus_if.jump_reg = jr;    bus_if.jr_target = tgt;
  endtask

  task automatic drive_seq();
    drive(0, 32'h2002_0001, 0, 32'h0, 0, 26'h0, 0, 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(logic [31:0] target);
    int guard;
    guard = 0;
    drive_seq();
    while (m_pc != target && guard < 300) begin
      cycle();
      guard++;
    end
    if (m_pc != target) begin
      checks++;
      errors++;
      $display("FAIL run_to got=%h exp=%h", m_pc, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive_seq();
    #1;
    apply_reset();

    // Boot then sequential 0,4,8
    cycle();
    check_val("boot_hold", bus_if.pc, 32'h0);
    cycle();
    check_val("seq_4", bus_if.pc, 32'h4);
    cycle();
    check_val("seq_8", bus_if.pc, 32'h8);

    // Branches backward and forward
    run_to(32'h10);
    drive(0, 32'h1, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0);
    cycle();
    check_val("branch_back", bus_if.pc, 32'h0C);
    run_to(32'h10);
    drive(0, 32'h1, 1, 32'h4, 0, 26'h0, 0, 32'h0);
    cycle();
    check_val("branch_fwd", bus_if.pc, 32'h24);

    // Priority jump_reg over jump/branch, sticky misaligned
    apply_reset();
    cycle();
    run_to(32'h18);
    drive(0, 32'h1, 1, 32'h4, 1, 26'd8, 1, 32'h22);
    cycle();
    check_val("jr_prio", bus_if.pc, 32'h20);
    check_val("mis_set", 32'(bus_if.misaligned), 32'h1);
    drive(0, 32'h1, 0, 32'h0, 1, 26'd100, 0, 32'h0);
    cycle();
    drive(0, 32'h1, 0, 32'h0, 0, 26'd0, 1, 32'h40);
    cycle();
    check_val("mis_sticky", 32'(bus_if.misaligned), 32'h1);

    // Stall holds pc with jump pending
    apply_reset();
    cycle();
    run_to(32'h14);
    drive(1, 32'h1, 0, 32'h0, 1, 26'd8, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle();
    check_val("stall_hold", bus_if.pc, 32'h14);
    bus_if.stall = 1'b0;
    cycle();
    check_val("stall_release_jump", bus_if.pc, 32'h20);

    // NOP run broken at the third NOP: no halt
    apply_reset();
    cycle();
    run_to(32'h70);
    for (int i = 0; i < 5; i++) begin
      drive_seq();
      bus_if.instruction = (i == 2) ? 32'h3 : 32'h0;
      cycle();
    end
    check_val("no_halt", 32'(bus_if.halted), 32'h0);

    // Four NOPs halt; control is then ignored
    apply_reset();
    cycle();
    run_to(32'h70);
    for (int i = 0; i < 4; i++) begin
      drive_seq();
      bus_if.instruction = 32'h0;
      cycle();
    end
    check_val("halt_flag", 32'(bus_if.halted), 32'h1);
    check_val("halt_pc", bus_if.pc, 32'h80);
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h5, 1, 32'h10, i[0], 26'h3, i[1], 32'h100);
      cycle();
    end
    check_val("halt_frozen", bus_if.pc, 32'h80);

    // Asynchronous reset out of HALT, between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_pc", bus_if.pc, 32'h0);
    check_val("async_rst_halted", 32'(bus_if.halted), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_val("async_rst_fetch_count", bus_if.fetch_count, 32'h0);
`endif
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) apply_reset();
      r = $urandom;
      drive($urandom_range(0, 3) == 0,
            ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom | 32'h1),
            $urandom_range(0, 2) == 0,
            {{16{r[15]}}, r[15:0]},
            $urandom_range(0, 5) == 0,
            26'($urandom),
            $urandom_range(0, 7) == 0,
            $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the single-cycle MIPS datapath. It sits directly upstream of instruction_memory.
- Holds the program counter and drives `pc` onto the instruction-memory address input.
- Each cycle it selects the next PC: sequential, branch, jump or jump-register.
- A small FSM sequences boot and run, and halts fetch when the program runs off into NOP fill.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_NOP_COUNT, 4: consecutive all-zero instructions that trigger HALT. 0 disables halt detection.
- NOP_CNT_W, 4: width of the NOP run counter. Must hold HALT_NOP_COUNT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and FSM for this cycle.
- instruction  in  32  word returned by instruction memory for the current `pc`.
- branch_taken  in  1  beq/bne resolved taken.
- branch_offset  in  32  sign-extended 16-bit immediate, in words.
- jump  in  1  j/jal.
- jump_index  in  26  instruction[25:0].
- jump_reg  in  1  jr.
- jr_target  in  32  rs register value.
- pc  out  32  current PC; feeds the instruction-memory address.
- pc_plus4  out  32  pc + 4; used as the jal link value.
- halted  out  1  fetch permanently stopped.
- misaligned  out  1  sticky; set when a jr target had bits[1:0] != 0.

Behaviour:
- Reset (asynchronous, active-low):
  - pc = RESET_PC, state = BOOT, NOP counter = 0, halted = 0, misaligned = 0.
  - Reset asserted mid-operation, including in HALT, returns to these values immediately.
- FSM states: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after reset deasserts. pc is held at RESET_PC so the memory output settles. Next state is RUN; stall is ignored in BOOT.
  - RUN: pc updates every cycle unless stall = 1. When stall = 1, pc, the NOP counter and the state all hold.
  - HALT: pc frozen, halted = 1, all control inputs ignored. The only exit is reset.
- pc_plus4 is combinational: pc + 4, 32-bit modulo. 32'hFFFF_FFFC wraps to 0.
- Next-PC priority in RUN when not stalled: jump_reg > jump > branch_taken > sequential.
  - jump_reg: {jr_target[31:2], 2'b00}. If jr_target[1:0] != 0, misaligned is set (sticky).
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch_taken: pc_plus4 + {branch_offset[29:0], 2'b00}, 32-bit modulo.
  - otherwise: pc_plus4.
  - Simultaneous control requests resolve by the priority above; there is no error.
- Halt detection (active only when HALT_NOP_COUNT > 0):
  - In RUN with stall = 0, an instruction of 32'h0 increments the NOP counter; any other value clears it.
  - When the counter would reach HALT_NOP_COUNT, the state moves to HALT on that edge. pc still takes its computed next value on that edge, then freezes.
  - A taken branch or jump does not clear the counter; only a non-zero instruction does.
- Latency: control inputs take effect on the next rising edge. The instruction for the new pc is available combinationally in the same cycle.

Optional Feature:
- FETCH_PERF_CNT_EN
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments on every RUN cycle with stall = 0, including the cycle that enters HALT. Saturates at 32'hFFFF_FFFF.
  - Adds output redirect_count [31:0], reset to 0. Increments when a non-sequential next PC is taken. Saturates the same way.
- Undefined: neither port nor its counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum (BOOT, RUN, HALT).
  - next_pc_sel_t enum (SEQ, BRANCH, JUMP, JREG).
  - constant NOP_INSTR = 32'h0.
  - constant WORD_BYTES = 4.
- One natural sub-module: next_pc_mux. Purely combinational priority select and target arithmetic. The PC register, FSM, NOP counter and optional counters stay in the top.

Test Plan:
- Release reset with RESET_PC = 0 → pc stays 0 for the BOOT cycle, then reads 0x0, 0x4, 0x8 on successive edges; pc_plus4 = pc + 4 throughout.
- At pc = 0x10, set branch_taken = 1, branch_offset = 32'hFFFF_FFFE → next pc = 0x0C. With branch_offset = 4 → next pc = 0x24.
- At pc = 0x18, assert jump, jump_reg and branch_taken together with jr_target = 0x22, jump_index = 8 → next pc = 0x20 and misaligned = 1. misaligned stays 1 after later jumps.
- Hold stall = 1 for 3 cycles at pc = 0x14 with jump = 1 → pc remains 0x14. First edge after stall deasserts → pc = {pc_plus4[31:28], jump_index, 2'b00}.
- Feed instruction = 0 at pc 0x70, 0x74, 0x78, 0x7C (HALT_NOP_COUNT = 4) → halted = 1 after the fourth edge with pc = 0x80. Further branch/jump inputs do not change pc. A non-zero instruction inserted at the third NOP resets the run, so no halt occurs.
- Assert rst_n = 0 asynchronously in HALT, between clock edges → pc = 0, halted = 0 immediately. With FETCH_PERF_CNT_EN defined, fetch_count = 0 as well.
